// File: rtl/data_memory.sv
// Byte-addressed data memory storing 16-bit big-endian words: synchronous
// two-byte write, combinational read, asynchronous clear on reset.
module data_memory #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Adresa,
    input  logic [15:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [15:0] ReadData
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] addr_hi;
    logic [AW-1:0] addr_lo;

    // Upper address bits are dropped, so the second byte wraps past DEPTH-1 to 0.
    assign addr_hi = Adresa[AW-1:0];
    assign addr_lo = addr_hi + AW'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (MemWrite) begin
            mem[addr_hi] <= WriteData[15:8];
            mem[addr_lo] <= WriteData[7:0];
        end
    end

    always_comb begin
        ReadData = 16'h0000;
        if (MemRead) begin
            ReadData = {mem[addr_hi], mem[addr_lo]};
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed stimulus pushes expected words into a queue,
// a monitor process compares each strobed read against the queue head.
module tb_data_memory;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Adresa = '0;
    logic [15:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [15:0] ReadData;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        chk_strobe = 1'b0;
    int          checks = 0;
    int          errors = 0;

    data_memory dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Adresa    (Adresa),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData)
    );

    // clock
    always #5 Clock = ~Clock;

    // monitor / scoreboard
    initial begin
        forever begin
            @(posedge chk_strobe);
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_sample: ReadData=%h with empty queue", ReadData);
            end else begin
                logic [15:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (ReadData !== e) begin
                    errors++;
                    $display("FAIL %s: ReadData=%h expected=%h", n, ReadData, e);
                end
            end
        end
    end

    // Issue one comparison against the current combinational output.
    task automatic expect_rd(input string n, input logic [15:0] e);
        #1;
        exp_q.push_back(e);
        name_q.push_back(n);
        chk_strobe = 1'b1;
        #1;
        chk_strobe = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge Clock);
        MemRead   = 1'b0;
        Adresa    = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge Clock);
        MemWrite  = 1'b0;
    endtask

    task automatic do_read(input string n, input logic [15:0] a, input logic [15:0] e);
        @(negedge Clock);
        Adresa  = a;
        MemRead = 1'b1;
        expect_rd(n, e);
    endtask

    initial begin
        // reset block
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        do_read("rst_a2",   16'd2,   16'h0000);
        do_read("rst_a0",   16'd0,   16'h0000);
        do_read("rst_a127", 16'd127, 16'h0000);

        do_write(16'd2, 16'h0069);
        do_read("basic_a2", 16'd2, 16'h0069);
        do_read("basic_a3", 16'd3, 16'h6900);
        @(negedge Clock);
        MemRead = 1'b0;
        Adresa  = 16'd2;
        expect_rd("read_disabled", 16'h0000);

        do_write(16'd4, 16'h1234);
        do_write(16'd5, 16'hABCD);
        do_read("overlap_a4", 16'd4, 16'h12AB);
        do_read("overlap_a5", 16'd5, 16'hABCD);
        do_read("overlap_a6", 16'd6, 16'hCD00);

        do_write(16'd127, 16'hBEEF);
        do_read("wrap_a127", 16'd127, 16'hBEEF);
        do_read("wrap_a0",   16'd0,   16'hEF00);
        do_write(16'd130, 16'h5A5A);
        do_read("alias_a2",  16'd2,   16'h5A5A);
        do_read("alias_a130", 16'd130, 16'h5A5A);

        // write enable gating and read-during-write
        @(negedge Clock);
        MemRead   = 1'b1;
        Adresa    = 16'd8;
        WriteData = 16'hCAFE;
        MemWrite  = 1'b0;
        expect_rd("we_off_before", 16'h0000);
        @(negedge Clock);
        expect_rd("we_off_after", 16'h0000);
        MemWrite = 1'b1;
        expect_rd("we_on_pre_edge", 16'h0000);
        @(negedge Clock);
        MemWrite = 1'b0;
        expect_rd("we_on_post_edge", 16'hCAFE);

        // async reset between edges
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        expect_rd("async_rst_a8", 16'h0000);
        Adresa = 16'd4;
        expect_rd("async_rst_a4", 16'h0000);

        // reset beats a simultaneous write
        @(negedge Clock);
        Adresa    = 16'd10;
        WriteData = 16'h7777;
        MemWrite  = 1'b1;
        @(negedge Clock);
        MemWrite = 1'b0;
        Reset    = 1'b0;
        do_read("rst_vs_write_a10", 16'd10, 16'h0000);
        do_read("rst_cleared_a5",   16'd5,  16'h0000);

        // first edge after deassert is honoured
        do_write(16'd20, 16'h1357);
        do_read("post_rst_write", 16'd20, 16'h1357);

        // drain, bounded
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
